// File: rtl/ram_model_if.sv
// ram_model_if: shared RAM state type plus the requester/RAM bus bundle.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface ram_model_if;
  import cpu_types_pkg::*;
  logic ramREN;
  logic ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t ramstate;
  modport master (output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
  modport slave (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/ram_model.sv
// ram_model: word RAM with LAT busy cycles per access; held requests complete once ACCESS is reached.
// Optional macro RAM_MODEL_ERROR_CHECK_EN flags REN+WEN together or out-of-range addresses as ERROR.
module ram_model
  import cpu_types_pkg::*;
#(
  parameter int LAT = 2,
  parameter int ADDR_BITS = 14
) (
  input logic CLK,
  input logic nRST,
  ram_model_if.slave bus
);
  logic [31:0] mem [2**ADDR_BITS];
  logic [3:0] cnt_q, cnt_d, ecnt;
  logic preq_q, preq_d;
  logic [33:0] lop_q, lop_d, cur;
  logic req, err, wr;
  logic [ADDR_BITS-1:0] idx;
  always_comb begin
    cur = {bus.ramREN, bus.ramWEN, bus.ramaddr};
    req = bus.ramREN | bus.ramWEN;
    idx = bus.ramaddr[ADDR_BITS+1:2];
`ifdef RAM_MODEL_ERROR_CHECK_EN
    err = (bus.ramREN & bus.ramWEN) | ((bus.ramaddr >> (ADDR_BITS + 2)) != 32'd0);
`else
    err = 1'b0;
`endif
    // any change of operation or address restarts the count as a fresh access
    ecnt = (preq_q && cur == lop_q) ? cnt_q : 4'd0;
    bus.ramstate = !req ? FREE : err ? ERROR : (ecnt == 4'(LAT)) ? ACCESS : BUSY;
    wr = (bus.ramstate == ACCESS) && bus.ramWEN;
    bus.ramload = (bus.ramstate == ACCESS && bus.ramREN && !bus.ramWEN) ? mem[idx] : 32'd0;
    preq_d = req;
    lop_d = req ? cur : lop_q;
    cnt_d = (bus.ramstate == BUSY) ? ecnt + 4'd1 : 4'd0;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
      preq_q <= 1'b0;
      lop_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      preq_q <= preq_d;
      lop_q <= lop_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (wr) mem[idx] <= bus.ramstore;
  end
endmodule

// File: tb/tb_ram_model.sv
// tb_ram_model: LAT=2 and LAT=0 instances against a cycle-timestamp reference model plus directed literal checks.
module tb_ram_model;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  ram_model_if b0();
  ram_model_if b1();
  ram_model #(.LAT(2), .ADDR_BITS(14)) dut0 (.CLK(CLK), .nRST(nRST), .bus(b0));
  ram_model #(.LAT(0), .ADDR_BITS(14)) dut1 (.CLK(CLK), .nRST(nRST), .bus(b1));

  logic ren [2];
  logic wen [2];
  logic [31:0] addr [2];
  logic [31:0] store [2];
  ramstate_t st [2];
  logic [31:0] ld [2];
  assign b0.ramREN = ren[0];
  assign b0.ramWEN = wen[0];
  assign b0.ramaddr = addr[0];
  assign b0.ramstore = store[0];
  assign b1.ramREN = ren[1];
  assign b1.ramWEN = wen[1];
  assign b1.ramaddr = addr[1];
  assign b1.ramstore = store[1];
  assign st[0] = b0.ramstate;
  assign st[1] = b1.ramstate;
  assign ld[0] = b0.ramload;
  assign ld[1] = b1.ramload;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] ref_mem [int];
  int start [2];
  logic prev_req [2];
  logic prev_done [2];
  logic rst_seen [2];
  logic pend [2];
  logic [33:0] prev_cur [2];
  int pend_key [2];
  logic [31:0] pend_data [2];

  function automatic int key(int i, logic [31:0] a);
    return i * 65536 + int'((a >> 2) & 32'h3FFF);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: an access starts the cycle its request first appears (or after reset/completion);
  // it is ACCESS exactly LAT cycles after that start.
  always @(posedge CLK) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) ref_mem[pend_key[i]] = pend_data[i];
      pend[i] = 1'b0;
      if (!nRST) rst_seen[i] = 1'b1;
    end
  end

  always @(negedge CLK) begin : cmp
    logic [33:0] cur;
    logic req, err;
    ramstate_t es;
    int lat, k;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 2 : 0;
      cur = {ren[i], wen[i], addr[i]};
      req = ren[i] | wen[i];
`ifdef RAM_MODEL_ERROR_CHECK_EN
      err = (ren[i] & wen[i]) | ((addr[i] >> 16) != 32'd0);
`else
      err = 1'b0;
`endif
      if (req && (rst_seen[i] || !nRST || !prev_req[i] || prev_cur[i] != cur || prev_done[i]))
        start[i] = cyc;
      es = !req ? FREE : err ? ERROR : (cyc - start[i] == lat) ? ACCESS : BUSY;
      k = key(i, addr[i]);
      chk($sformatf("model_state%0d", i), 32'(st[i]), 32'(es));
      if (es == ACCESS && ren[i] && !wen[i]) begin
        if (ref_mem.exists(k)) chk($sformatf("model_load%0d", i), ld[i], ref_mem[k]);
      end else chk($sformatf("model_load%0d", i), ld[i], 32'd0);
      pend[i] = (es == ACCESS) && wen[i];
      pend_key[i] = k;
      pend_data[i] = store[i];
      prev_req[i] = req;
      prev_cur[i] = cur;
      prev_done[i] = (es == ACCESS) || (es == ERROR);
      rst_seen[i] = 1'b0;
    end
  end

  task automatic nx();
    @(posedge CLK);
    #1;
  endtask

  task automatic lit(string n, int i, ramstate_t s, logic [31:0] l);
    @(negedge CLK);
    chk({n, "_st"}, 32'(st[i]), 32'(s));
    chk({n, "_ld"}, ld[i], l);
    nx();
  endtask

  task automatic lit_st(string n, int i, ramstate_t s);
    @(negedge CLK);
    chk({n, "_st"}, 32'(st[i]), 32'(s));
    nx();
  endtask

  task automatic idle(int i);
    ren[i] = 1'b0;
    wen[i] = 1'b0;
  endtask

  logic [31:0] atab [6] = '{32'h0, 32'h4, 32'h40, 32'h100, 32'h300, 32'h8000_0040};

  initial begin
    for (int i = 0; i < 2; i++) begin
      ren[i] = 1'b0;
      wen[i] = 1'b0;
      addr[i] = '0;
      store[i] = '0;
      start[i] = 0;
      prev_req[i] = 1'b0;
      prev_done[i] = 1'b0;
      rst_seen[i] = 1'b0;
      pend[i] = 1'b0;
      prev_cur[i] = '0;
      pend_key[i] = 0;
      pend_data[i] = '0;
    end
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    repeat (3) lit("idle", 0, FREE, 32'd0);
    // write then read back 0x100
    wen[0] = 1'b1; addr[0] = 32'h100; store[0] = 32'hDEAD_BEEF;
    lit("w100_b1", 0, BUSY, 32'd0);
    lit("w100_b2", 0, BUSY, 32'd0);
    lit("w100_acc", 0, ACCESS, 32'd0);
    wen[0] = 1'b0; ren[0] = 1'b1;
    lit("r100_b1", 0, BUSY, 32'd0);
    lit("r100_b2", 0, BUSY, 32'd0);
    lit("r100_acc", 0, ACCESS, 32'hDEAD_BEEF);
    idle(0);
    lit("idle2", 0, FREE, 32'd0);
    // address change mid-BUSY restarts the count
    ren[0] = 1'b1; addr[0] = 32'h200;
    lit_st("r200_b1", 0, BUSY);
    addr[0] = 32'h204;
    lit_st("r204_b1", 0, BUSY);
    lit_st("r204_b2", 0, BUSY);
    lit_st("r204_acc", 0, ACCESS);
    idle(0);
    lit("idle3", 0, FREE, 32'd0);
    // reset during the second BUSY of a write abandons it
    wen[0] = 1'b1; addr[0] = 32'h300; store[0] = 32'h1234;
    lit("w300_b1", 0, BUSY, 32'd0);
    @(negedge CLK);
    chk("w300_b2_st", 32'(st[0]), 32'(BUSY));
    #1 nRST = 1'b0;
    nx();
    nRST = 1'b1;
    lit("w300_rb1", 0, BUSY, 32'd0);
    lit("w300_rb2", 0, BUSY, 32'd0);
    lit("w300_acc", 0, ACCESS, 32'd0);
    wen[0] = 1'b0; ren[0] = 1'b1;
    lit("r300_b1", 0, BUSY, 32'd0);
    lit("r300_b2", 0, BUSY, 32'd0);
    lit("r300_acc", 0, ACCESS, 32'h1234);
    idle(0);
    lit("idle4", 0, FREE, 32'd0);
    // LAT=0: every held cycle is its own ACCESS
    wen[1] = 1'b1; addr[1] = 32'h100; store[1] = 32'hCAFE_F00D;
    lit("l0_w", 1, ACCESS, 32'd0);
    wen[1] = 1'b0; ren[1] = 1'b1;
    repeat (3) lit("l0_r", 1, ACCESS, 32'hCAFE_F00D);
    idle(1);
    lit("l0_idle", 1, FREE, 32'd0);
    // REN+WEN together at 0x40
    wen[0] = 1'b1; addr[0] = 32'h40; store[0] = 32'h1111_1111;
    lit("w40_b1", 0, BUSY, 32'd0);
    lit("w40_b2", 0, BUSY, 32'd0);
    lit("w40_acc", 0, ACCESS, 32'd0);
    idle(0);
    lit("idle5", 0, FREE, 32'd0);
    ren[0] = 1'b1; wen[0] = 1'b1; store[0] = 32'h5A5A_5A5A;
`ifdef RAM_MODEL_ERROR_CHECK_EN
    repeat (3) lit("rw40_err", 0, ERROR, 32'd0);
    wen[0] = 1'b0; addr[0] = 32'h8000_0000;
    lit("hi_err", 0, ERROR, 32'd0);
    addr[0] = 32'h40;
    idle(0);
    lit("idle6", 0, FREE, 32'd0);
    ren[0] = 1'b1;
    lit("r40_b1", 0, BUSY, 32'd0);
    lit("r40_b2", 0, BUSY, 32'd0);
    lit("r40_acc", 0, ACCESS, 32'h1111_1111);
`else
    lit("rw40_b1", 0, BUSY, 32'd0);
    lit("rw40_b2", 0, BUSY, 32'd0);
    lit("rw40_acc", 0, ACCESS, 32'd0);
    idle(0);
    lit("idle6", 0, FREE, 32'd0);
    ren[0] = 1'b1;
    lit("r40_b1", 0, BUSY, 32'd0);
    lit("r40_b2", 0, BUSY, 32'd0);
    lit("r40_acc", 0, ACCESS, 32'h5A5A_5A5A);
`endif
    idle(0);
    nx();
    // randomized traffic with occasional resets, checked by the model every cycle
    for (int n = 0; n < 600; n++) begin
      nRST = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          logic [1:0] r;
          r = 2'($urandom_range(0, 3));
          ren[i] = r[0];
          wen[i] = r[1];
          addr[i] = atab[$urandom_range(0, 5)];
          store[i] = $urandom;
        end
      end
      nx();
    end
    nRST = 1'b1;
    idle(0);
    idle(1);
    nx();
    nx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_model.md
RAM_MODEL -- requirements
Module: ram_model

Interface
REQ-001 SHALL provide parameter LAT, default 2, meaning the number of BUSY cycles before ACCESS (legal range 0-15).
REQ-002 SHALL provide parameter ADDR_BITS, default 14, meaning log2 of the word depth (16384 words).
REQ-003 SHALL provide port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port nRST, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port ramREN, input, 1, read request, level held by the requester until ACCESS.
REQ-006 SHALL provide port ramWEN, input, 1, write request, level held by the requester until ACCESS.
REQ-007 SHALL provide port ramaddr, input, 32, byte address; bits [1:0] ignored.
REQ-008 SHALL provide port ramstore, input, 32, write data.
REQ-009 SHALL provide port ramload, output, 32, read data.
REQ-010 SHALL provide port ramstate, output, ramstate_t (2 bits) from cpu_types_pkg, with values FREE, BUSY, ACCESS, ERROR.

Function
REQ-011 SHALL store words in mem[ADDR_BITS-bit index], with index = ramaddr[ADDR_BITS+1:2].
REQ-012 SHALL register a latency counter cnt (4 bits), a previous-request flag preq, and a latched request lop = {REN, WEN, addr}.
REQ-013 SHALL compute effective count ecnt = cnt when preq=1 and the current {ramREN, ramWEN, ramaddr} equals lop; otherwise ecnt = 0, meaning a new access.
REQ-014 SHALL drive ramstate combinationally in this priority order:
- no request -> FREE;
- error condition (REQ-025) -> ERROR;
- ecnt == LAT -> ACCESS;
- otherwise -> BUSY.
REQ-015 SHALL update state each edge while a request is present:
- lop <= current request; preq <= 1;
- cnt <= 0 if ramstate is ACCESS, else ecnt+1.
REQ-016 SHALL set preq <= 0 and cnt <= 0 on any edge with no request.
REQ-017 SHALL, with LAT=0, report ACCESS in the same cycle the request first appears.
REQ-018 SHALL start a new access, with a full LAT BUSY cycles, when a request is still held in the cycle after ACCESS.
REQ-019 SHALL, when ramaddr or the operation changes mid-BUSY, restart the latency count from 0 with no partial completion.
REQ-020 SHALL commit a write, mem[index] <= ramstore, only on the rising edge ending an ACCESS cycle with ramWEN=1.
REQ-021 SHALL drive ramload = mem[index] combinationally during an ACCESS cycle with ramREN=1; ramload = 0 in all other cycles.
REQ-022 SHALL, when ramREN and ramWEN are both 1 with the macro absent, treat the request as a write: ramload = 0 and the write commits.
REQ-023 SHALL never commit a write during FREE, BUSY or ERROR.

Reset
REQ-024 SHALL, on nRST=0, immediately clear cnt, preq and lop to 0; ramstate then follows REQ-014 (FREE if no request, BUSY/ACCESS per ecnt=0); mem contents are unaffected; an access in flight is abandoned and restarts from 0 after release.

Configuration
REQ-025 SHALL support macro RAM_MODEL_ERROR_CHECK_EN. When defined, ramstate = ERROR whenever ramREN and ramWEN are both 1, or ramaddr[31:ADDR_BITS+2] is nonzero. In ERROR: no write commits, ramload = 0, cnt is held at 0. When undefined: no ERROR is ever produced; upper address bits alias; REN+WEN behaves as a write.

Verification
REQ-026 Reset, then idle with LAT=2 -> ramstate FREE and ramload 0 every cycle.
REQ-027 LAT=2: hold ramWEN, addr 0x100, data 0xDEADBEEF -> BUSY, BUSY, ACCESS; then hold ramREN at 0x100 -> BUSY, BUSY, ACCESS with ramload 0xDEADBEEF in the ACCESS cycle only.
REQ-028 LAT=2: read 0x200, change addr to 0x204 after 1 BUSY -> counting restarts: BUSY, BUSY, ACCESS from the change; no ACCESS for 0x200.
REQ-029 LAT=2: write 0x300 = 0x1234, assert nRST=0 during the 2nd BUSY cycle, release, and hold the request -> state restarts at BUSY; the write commits exactly once at the later ACCESS; a readback returns 0x1234.
REQ-030 LAT=0: REN held at 0x100 for 3 cycles -> ACCESS every cycle, ramload valid each cycle.
REQ-031 With RAM_MODEL_ERROR_CHECK_EN: REN=WEN=1 at 0x40, or REN at 0x80000000 -> ERROR, no write, ramload 0; without the macro, the same REN=WEN=1 stimulus writes ramstore to 0x40.
